// File: rtl/conv_pkg.sv
// Shared constants, tap indices and FSM encoding for the layer-0 window generator.
package conv_pkg;

   localparam int DATA_W = 20;
   localparam int IMG_W  = 64;
   localparam int ADDR_W = 12;

   // Coordinate width inside the image, plus one bit so the scan can reach IMG_W.
   localparam int CRD_W = $clog2(IMG_W);
   localparam int POS_W = CRD_W + 1;
   localparam int NTAPS = 9;

   localparam int TAP_NW = 0;
   localparam int TAP_N  = 1;
   localparam int TAP_NE = 2;
   localparam int TAP_W  = 3;
   localparam int TAP_C  = 4;
   localparam int TAP_E  = 5;
   localparam int TAP_SW = 6;
   localparam int TAP_S  = 7;
   localparam int TAP_SE = 8;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      CAPTURE,
      EMIT,
      DONE
   } state_t;

endpackage

// File: rtl/conv_line_buf.sv
// Two-row line buffer: one shared index, rows cascade lb0 -> lb1 on each write.
module conv_line_buf
   import conv_pkg::*;
#(
   parameter int W     = DATA_W,
   parameter int DEPTH = IMG_W
) (
   input  logic                     clk,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] idx_i,
   input  logic [W-1:0]             wdata_i,
   output logic [W-1:0]             rd0_o,
   output logic [W-1:0]             rd1_o
);

   logic [W-1:0] lb0_q [DEPTH];
   logic [W-1:0] lb1_q [DEPTH];

   // Reads return the pre-write contents, so the caller sees rows r-1 and r-2.
   assign rd0_o = lb0_q[idx_i];
   assign rd1_o = lb1_q[idx_i];

   always_ff @(posedge clk) begin
      if (we_i) begin
         lb1_q[idx_i] <= lb0_q[idx_i];
         lb0_q[idx_i] <= wdata_i;
      end
   end

endmodule

// File: rtl/conv_window_gen.sv
// Raster-scan 3x3 zero-padded window generator feeding the layer-0 convolver.
// Optional WINGEN_PAD_MASK_EN adds win_pad_mask (one bit per tap lying outside the image).
module conv_window_gen
   import conv_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   output logic                    busy,
   output logic                    done,
   output logic [ADDR_W-1:0]       iaddr,
   output logic                    ird,
   input  logic [DATA_W-1:0]       idata,
   output logic                    win_valid,
   input  logic                    win_ready,
   output logic [NTAPS*DATA_W-1:0] win_data,
   output logic [CRD_W-1:0]        win_row,
   output logic [CRD_W-1:0]        win_col,
   output logic                    win_last
`ifdef WINGEN_PAD_MASK_EN
  ,output logic [8:0]              win_pad_mask
`endif
);

   localparam logic [POS_W-1:0] IMG_END = POS_W'(IMG_W);

   state_t                        state_q, state_d;
   logic [POS_W-1:0]              pr_q, pr_d, pc_q, pc_d, pr_nx, pc_nx;
   logic [NTAPS-1:0][DATA_W-1:0]  win_q, win_d, win_base;
   logic [CRD_W-1:0]              row_q, row_d, col_q, col_d;
   logic                          last_q, last_d;
   logic [2:0][DATA_W-1:0]        new_col;
   logic [DATA_W-1:0]             lb0_rd, lb1_rd, pix_new;
   logic                          pr_in, pc_in, in_img, lb_we, to_emit;

   assign pr_in   = pr_q < IMG_END;
   assign pc_in   = pc_q < IMG_END;
   assign in_img  = pr_in && pc_in;
   assign to_emit = (pr_q != '0) && (pc_q != '0);
   assign pix_new = in_img ? idata : '0;
   assign lb_we   = (state_q == CAPTURE) && pc_in;

   conv_line_buf #(.W(DATA_W), .DEPTH(IMG_W)) u_lb (
      .clk     (clk),
      .we_i    (lb_we),
      .idx_i   (pc_q[CRD_W-1:0]),
      .wdata_i (pix_new),
      .rd0_o   (lb0_rd),
      .rd1_o   (lb1_rd)
   );

   // Top padding falls out of the row gating; right/bottom padding out of pc/pr == IMG_W.
   assign new_col[0] = (pc_in && pr_q >= POS_W'(2)) ? lb1_rd : '0;
   assign new_col[1] = (pc_in && pr_q != '0)        ? lb0_rd : '0;
   assign new_col[2] = pix_new;
   assign win_base   = (pc_q == '0) ? '0 : win_q;

   always_comb begin
      pc_nx = pc_q + POS_W'(1);
      pr_nx = pr_q;
      if (pc_q == IMG_END) begin
         pc_nx = '0;
         pr_nx = pr_q + POS_W'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      pr_d    = pr_q;
      pc_d    = pc_q;
      win_d   = win_q;
      row_d   = row_q;
      col_d   = col_q;
      last_d  = last_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = FETCH;
               pr_d    = '0;
               pc_d    = '0;
            end
         end
         FETCH: state_d = CAPTURE;
         CAPTURE: begin
            win_d[TAP_NW] = win_base[TAP_N];
            win_d[TAP_N]  = win_base[TAP_NE];
            win_d[TAP_NE] = new_col[0];
            win_d[TAP_W]  = win_base[TAP_C];
            win_d[TAP_C]  = win_base[TAP_E];
            win_d[TAP_E]  = new_col[1];
            win_d[TAP_SW] = win_base[TAP_S];
            win_d[TAP_S]  = win_base[TAP_SE];
            win_d[TAP_SE] = new_col[2];
            if (to_emit) begin
               state_d = EMIT;
               row_d   = CRD_W'(pr_q - POS_W'(1));
               col_d   = CRD_W'(pc_q - POS_W'(1));
               last_d  = (pr_q == IMG_END) && (pc_q == IMG_END);
            end else begin
               state_d = FETCH;
               pr_d    = pr_nx;
               pc_d    = pc_nx;
            end
         end
         EMIT: begin
            if (win_ready) begin
               last_d = 1'b0;
               if (last_q) begin
                  state_d = DONE;
               end else begin
                  state_d = FETCH;
                  pr_d    = pr_nx;
                  pc_d    = pc_nx;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         pr_q    <= '0;
         pc_q    <= '0;
         win_q   <= '0;
         row_q   <= '0;
         col_q   <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pr_q    <= pr_d;
         pc_q    <= pc_d;
         win_q   <= win_d;
         row_q   <= row_d;
         col_q   <= col_d;
         last_q  <= last_d;
      end
   end

   // Row-major address reduces to a concatenation because IMG_W is a power of two.
   assign ird       = (state_q == FETCH) && in_img;
   assign iaddr     = ird ? ADDR_W'({pr_q[CRD_W-1:0], pc_q[CRD_W-1:0]}) : '0;
   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);
   assign win_valid = (state_q == EMIT);
   assign win_data  = win_q;
   assign win_row   = row_q;
   assign win_col   = col_q;
   assign win_last  = last_q;

`ifdef WINGEN_PAD_MASK_EN
   logic [8:0] mask_q, mask_d;
   logic [2:0] row_out, col_out;

   // Index 0 is the top row / left column of the window about to be emitted.
   assign row_out = {pr_q == IMG_END, 1'b0, pr_q == POS_W'(1)};
   assign col_out = {pc_q == IMG_END, 1'b0, pc_q == POS_W'(1)};

   always_comb begin
      mask_d = mask_q;
      if (state_q == CAPTURE && to_emit) begin
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               mask_d[3*r+c] = row_out[r] | col_out[c];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) mask_q <= '0;
      else       mask_q <= mask_d;
   end

   assign win_pad_mask = mask_q;
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen over a ramp image (pixel value = its address).
module tb_conv_window_gen;
   import conv_pkg::*;

   localparam int WIN_W = NTAPS*DATA_W;
   localparam int NWIN  = IMG_W*IMG_W;
   localparam int NDIR  = 13;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic              win_ready = 1'b1;
   logic              busy, done, ird, win_valid, win_last;
   logic [ADDR_W-1:0] iaddr;
   logic [DATA_W-1:0] idata;
   logic [WIN_W-1:0]  win_data;
   logic [CRD_W-1:0]  win_row, win_col;
`ifdef WINGEN_PAD_MASK_EN
   logic [8:0]        win_pad_mask;
`endif

   conv_window_gen dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .iaddr     (iaddr),
      .ird       (ird),
      .idata     (idata),
      .win_valid (win_valid),
      .win_ready (win_ready),
      .win_data  (win_data),
      .win_row   (win_row),
      .win_col   (win_col),
      .win_last  (win_last)
`ifdef WINGEN_PAD_MASK_EN
     ,.win_pad_mask (win_pad_mask)
`endif
   );

   always #5 clk = ~clk;

   // Image memory: one-cycle read latency; junk when not read so padding leaks show up.
   always @(posedge clk) idata <= ird ? DATA_W'(iaddr) : 20'hBAD5A;

   typedef struct {
      int               row;
      int               col;
      int               last;
      logic [WIN_W-1:0] data;
      logic [8:0]       mask;
   } exp_t;

   exp_t sb[$];
   exp_t e_mon;
   int   n_cmp = 0, n_err = 0, n_acc = 0, cyc = 0, acc_cyc = -1;

   // Hand-computed taps at selected windows: row, col, tap, value.
   int dir_r[NDIR] = '{0, 0, 0, 0, 0, 63, 63, 63, 63, 63, 10, 10, 10};
   int dir_c[NDIR] = '{0, 0, 0, 0, 0, 63, 63, 63, 63, 63, 20, 20, 20};
   int dir_k[NDIR] = '{4, 5, 7, 8, 0, 0, 1, 3, 4, 8, 0, 4, 8};
   int dir_v[NDIR] = '{0, 1, 64, 65, 0, 4030, 4031, 4094, 4095, 0, 595, 660, 725};

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic chkd(input string nm, input logic [WIN_W-1:0] act, input logic [WIN_W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic exp_t model(input int r, input int c);
      exp_t e;
      int   rr, cc;
      e.row  = r;
      e.col  = c;
      e.last = (r == IMG_W-1 && c == IMG_W-1) ? 1 : 0;
      e.data = '0;
      e.mask = '0;
      for (int k = 0; k < 9; k++) begin
         rr = r + k/3 - 1;
         cc = c + k%3 - 1;
         if (rr < 0 || rr >= IMG_W || cc < 0 || cc >= IMG_W) e.mask[k] = 1'b1;
         else e.data[k*DATA_W +: DATA_W] = DATA_W'(rr*IMG_W + cc);
      end
      return e;
   endfunction

   task automatic load_sb();
      for (int r = 0; r < IMG_W; r++)
         for (int c = 0; c < IMG_W; c++)
            sb.push_back(model(r, c));
   endtask

   // Monitor: every accepted window is popped from the scoreboard and compared.
   always @(negedge clk) begin
      if (!reset && win_valid && win_ready) begin
         n_acc++;
         if (sb.size() == 0) begin
            chk("sb_nonempty", 0, 1);
         end else begin
            e_mon = sb.pop_front();
            chk("win_row", int'(win_row), e_mon.row);
            chk("win_col", int'(win_col), e_mon.col);
            chk("win_last", int'(win_last), e_mon.last);
            chkd("win_data", win_data, e_mon.data);
`ifdef WINGEN_PAD_MASK_EN
            chk("win_pad_mask", int'(win_pad_mask), int'(e_mon.mask));
`endif
         end
         for (int i = 0; i < NDIR; i++)
            if (int'(win_row) == dir_r[i] && int'(win_col) == dir_c[i])
               chk("dir_tap", int'(win_data[dir_k[i]*DATA_W +: DATA_W]), dir_v[i]);
         if (win_last) acc_cyc = cyc;
      end
   end

   task automatic run_pass(input bit poke, input bit timed);
      int st_cyc;
      bit got;
      n_acc   = 0;
      acc_cyc = -1;
      got     = 1'b0;
      load_sb();
      start  = 1'b1;
      st_cyc = cyc;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", int'(busy), 1);
      for (int i = 0; i < 20000 && !got; i++) begin
         @(negedge clk);
         if (done) got = 1'b1;
         if (poke && i == 98) start = 1'b1;
         if (poke && i == 99) start = 1'b0;
      end
      if (!got) begin
         chk("done_timeout", 0, 1);
         return;
      end
      chk("done_after_last_accept", cyc, acc_cyc + 1);
      if (timed) chk("final_accept_cycle", acc_cyc - st_cyc, 12546);
      chk("busy_in_done", int'(busy), 1);
      @(negedge clk);
      chk("done_one_cycle", int'(done), 0);
      chk("busy_cleared", int'(busy), 0);
      chk("window_count", n_acc, NWIN);
      chk("sb_drained", sb.size(), 0);
   endtask

   task automatic stall_test();
      exp_t e;
      bit   got;
      got = 1'b0;
      e   = model(5, 7);
      for (int i = 0; i < 20000 && !got; i++) begin
         @(posedge clk);
         #1;
         if (win_valid && win_row == 6'd5 && win_col == 6'd7) got = 1'b1;
      end
      if (!got) begin
         chk("stall_timeout", 0, 1);
         return;
      end
      win_ready = 1'b0;
      repeat (10) begin
         @(negedge clk);
         chk("stall_valid", int'(win_valid), 1);
         chk("stall_ird", int'(ird), 0);
         chk("stall_row", int'(win_row), 5);
         chk("stall_col", int'(win_col), 7);
         chkd("stall_data", win_data, e.data);
      end
      @(posedge clk);
      #1;
      win_ready = 1'b1;
   endtask

   task automatic reset_mid_test();
      bit got;
      got = 1'b0;
      load_sb();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 20000 && !got; i++) begin
         @(posedge clk);
         #1;
         if (win_valid && win_row == 6'd30 && win_col == 6'd30) got = 1'b1;
      end
      if (!got) chk("reset_wait_timeout", 0, 1);
      #2 reset = 1'b1;
      #1;
      chk("rst_mid_busy", int'(busy), 0);
      chk("rst_mid_valid", int'(win_valid), 0);
      chk("rst_mid_ird", int'(ird), 0);
      chk("rst_mid_done", int'(done), 0);
      chk("rst_mid_row", int'(win_row), 0);
      chk("rst_mid_col", int'(win_col), 0);
      chk("rst_mid_last", int'(win_last), 0);
      chkd("rst_mid_data", win_data, '0);
      sb.delete();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_ird", int'(ird), 0);
      chk("rst_iaddr", int'(iaddr), 0);
      chk("rst_valid", int'(win_valid), 0);
      chk("rst_row", int'(win_row), 0);
      chk("rst_col", int'(win_col), 0);
      chk("rst_last", int'(win_last), 0);
      chkd("rst_data", win_data, '0);
`ifdef WINGEN_PAD_MASK_EN
      chk("rst_mask", int'(win_pad_mask), 0);
`endif
      reset = 1'b0;
      @(negedge clk);

      // Full pass, ready high, with a stray start while busy.
      run_pass(1'b1, 1'b1);
      // Back-pressure at window (5,7).
      fork
         run_pass(1'b0, 1'b0);
         stall_test();
      join
      // Reset during EMIT of (30,30), then a clean restart from (0,0).
      reset_mid_test();
      run_pass(1'b0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
